// File: rtl/vga_timing_gen.sv
// 640x480@60 pixel-timing generator: hpos/vpos, display_on, syncs, line/frame strobes.
// Define VGA_TIMING_FRAME_CNT_EN to build the 8-bit frame counter; otherwise frame_cnt is tied 0.
module vga_timing_gen #(
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter bit SYNC_NEG  = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ce,
  output logic [9:0] hpos,
  output logic [9:0] vpos,
  output logic       display_on,
  output logic       hsync,
  output logic       vsync,
  output logic       line_start,
  output logic       frame_start,
  output logic [7:0] frame_cnt
);
  // Totals must fit the 10-bit counters (<= 1024).
  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_DE   = 10'(H_DISPLAY);
  localparam logic [9:0] V_DE   = 10'(V_DISPLAY);
  localparam logic [9:0] HS_BEG = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] HS_END = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_BEG = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] VS_END = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  logic       h_wrap, v_wrap;
  logic [9:0] h_nxt, v_nxt;
  logic       de_nxt, hs_act, vs_act;

  // Outputs are decoded from the next counter values so every registered
  // output lines up with the registered hpos/vpos (no skew).
  always_comb begin
    h_wrap = (hpos == H_LAST);
    v_wrap = (vpos == V_LAST);
    h_nxt  = h_wrap ? 10'd0 : hpos + 10'd1;
    v_nxt  = vpos;
    if (h_wrap) v_nxt = v_wrap ? 10'd0 : vpos + 10'd1;
    de_nxt = (h_nxt < H_DE) && (v_nxt < V_DE);
    hs_act = (h_nxt >= HS_BEG) && (h_nxt <= HS_END);
    vs_act = (v_nxt >= VS_BEG) && (v_nxt <= VS_END);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hpos        <= H_LAST;
      vpos        <= V_LAST;
      display_on  <= 1'b0;
      hsync       <= SYNC_NEG;
      vsync       <= SYNC_NEG;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      if (ce) begin
        hpos        <= h_nxt;
        vpos        <= v_nxt;
        display_on  <= de_nxt;
        hsync       <= hs_act ^ SYNC_NEG;
        vsync       <= vs_act ^ SYNC_NEG;
        line_start  <= h_wrap;
        frame_start <= h_wrap && v_wrap;
      end
    end
  end

`ifdef VGA_TIMING_FRAME_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      frame_cnt <= 8'd0;
    else if (ce && h_wrap && v_wrap) frame_cnt <= frame_cnt + 8'd1;
  end
`else
  assign frame_cnt = 8'd0;
`endif

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Pixel-timing generator feeding the colour-bar and pattern stages: produces hpos/vpos, display_on and hsync/vsync for 640x480@60 Hz on the TinyVGA PMOD.
- Downstream pattern logic decodes bars from hpos/vpos. It gates colour to 0 outside display_on and animates on vsync edges.
- Adds a pixel clock enable, line and frame strobes, and an optional frame counter.

Parameters:
- H_DISPLAY, 640: visible pixels per line
- H_FRONT, 16: horizontal front porch, in pixels
- H_SYNC, 96: hsync pulse width, in pixels
- H_BACK, 48: horizontal back porch, in pixels
- V_DISPLAY, 480: visible lines
- V_FRONT, 10: vertical front porch, in lines
- V_SYNC, 2: vsync width, in lines
- V_BACK, 33: vertical back porch, in lines
- SYNC_NEG, 1: 1 = syncs active-low; 0 = syncs active-high

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous, active-low
- ce  in  1  pixel enable; counters advance only on clk edges with ce=1
- hpos  out  10  horizontal position, 0..H_TOTAL-1
- vpos  out  10  vertical position, 0..V_TOTAL-1
- display_on  out  1  high when hpos<H_DISPLAY and vpos<V_DISPLAY
- hsync  out  1  horizontal sync, polarity set by SYNC_NEG
- vsync  out  1  vertical sync, polarity set by SYNC_NEG
- line_start  out  1  one-clk pulse when hpos becomes 0
- frame_start  out  1  one-clk pulse when hpos and vpos both become 0
- frame_cnt  out  8  frame counter (only with FRAME_CNT_EN; otherwise tied 0)

Behaviour:
- Derived constants: H_TOTAL = sum of the four H params (default 800); V_TOTAL = sum of the four V params (default 525). Both must be <= 1024 (10-bit counters).
- All outputs are registered. Output values correspond to the current hpos/vpos, with no pipeline skew between any outputs.
- Reset (async, rst_n=0):
  - hpos=H_TOTAL-1, vpos=V_TOTAL-1
  - display_on=0; hsync, vsync inactive (1 when SYNC_NEG=1)
  - line_start=0, frame_start=0, frame_cnt=0
- First ce tick after reset release: hpos=0, vpos=0, display_on=1, and line_start and frame_start both pulse.
- ce tick, horizontal: hpos increments. If hpos==H_TOTAL-1, hpos wraps to 0.
- ce tick, vertical: vpos increments only on an hpos wrap. If vpos==V_TOTAL-1 at that wrap, vpos wraps to 0.
- ce=0: all counters and levels hold, and both strobes are 0. Strobes are high exactly one clk cycle, the cycle after the qualifying ce tick.
- hsync active iff H_DISPLAY+H_FRONT <= hpos <= H_DISPLAY+H_FRONT+H_SYNC-1 (default 656..751).
- vsync active iff V_DISPLAY+V_FRONT <= vpos <= V_DISPLAY+V_FRONT+V_SYNC-1 (default 490..491). vsync changes only in the cycle hpos becomes 0.
- Simultaneous hpos and vpos wrap: frame_start and line_start pulse together.
- Reset mid-frame: immediately returns to the reset state. No partial-frame strobe is emitted.
- ce is sampled synchronously. rst_n release is assumed synchronised externally.

Optional Feature:
- Macro: VGA_TIMING_FRAME_CNT_EN.
- When defined: frame_cnt is an 8-bit register. It increments modulo 256 in the same clk edge that loads hpos=0, vpos=0, so it updates coincident with frame_start. The first frame after reset reads 1.
- When undefined: frame_cnt is constant 0 and no register is built.

Test Plan:
- Reset then release with ce=1 → cycle 0: hpos=799, vpos=524, display_on=0, hsync=vsync=1. Next cycle: hpos=0, vpos=0, display_on=1, line_start=1, frame_start=1.
- Free-run one line with ce=1 → hsync=0 exactly for hpos 656..751 (96 cycles). display_on falls at hpos=640. line_start pulses once per 800 clks.
- Free-run one frame → vsync=0 for vpos 490..491 (1600 clks). frame_start period = 420000 clks. vpos wraps 524→0 at the same edge as hpos 799→0.
- ce toggling 1/0 every clk → counters advance every 2 clks. Strobes stay one clk wide. Frame period = 840000 clks.
- Assert rst_n=0 asynchronously at hpos=300, vpos=200 (mid-clock) → outputs go immediately to reset values, and no strobe is emitted.
- With VGA_TIMING_FRAME_CNT_EN, run 257 frames → frame_cnt reads 1,2,…,255,0,1, each step coincident with frame_start. Without the macro, frame_cnt=0 throughout.
